// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and constants for the UART transmit arbiter
package uart_pkg;

   localparam int         UART_DATA_W     = 8;
   localparam logic [3:0] UART_TAG_PREFIX = 4'hA;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      ACCEPT = 2'd2,
      DRAIN  = 2'd3
   } uart_arb_state_e;

   // Source tag byte sent ahead of the data byte when tagging is enabled.
   function automatic logic [UART_DATA_W-1:0] uart_src_tag(input logic [3:0] id);
      return {UART_TAG_PREFIX, id};
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, searches from rr_ptr+1 upward modulo NUM_REQ
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [ID_W-1:0]    winner,
   output logic               valid
);

   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      valid  = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!valid && req[idx[ID_W-1:0]]) begin
            valid  = 1'b1;
            winner = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter; UART_SRC_TAG_EN prefixes each byte with a source tag
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = UART_DATA_W,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic                      tx_wr_en,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_busy,
   output logic [ID_W-1:0]           grant_id,
   output logic                      active
);

   uart_arb_state_e    state_q;
   logic [ID_W-1:0]    rr_ptr_q;
   logic [ID_W-1:0]    grant_id_q;
   logic [NUM_REQ-1:0] ack_q;
   logic               tx_wr_en_q;
   logic [DATA_W-1:0]  tx_data_q;
`ifdef UART_SRC_TAG_EN
   logic               tag_phase_q;
   logic [DATA_W-1:0]  data_hold_q;
`endif

   logic [ID_W-1:0]    winner;
   logic               win_valid;
   logic [DATA_W-1:0]  win_byte;
   logic [NUM_REQ-1:0] grant_onehot;
   logic               accepted;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .winner (winner),
      .valid  (win_valid)
   );

   always_comb begin
      win_byte     = '0;
      grant_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == ID_W'(i)) win_byte = req_data[i*DATA_W +: DATA_W];
         grant_onehot[i] = (grant_id_q == ID_W'(i));
      end
   end

   // Busy only counts as acceptance once our strobe has actually been presented.
   assign accepted = tx_wr_en_q && tx_busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= ID_W'(NUM_REQ - 1);
         grant_id_q  <= '0;
         ack_q       <= '0;
         tx_wr_en_q  <= 1'b0;
         tx_data_q   <= '0;
`ifdef UART_SRC_TAG_EN
         tag_phase_q <= 1'b0;
         data_hold_q <= '0;
`endif
      end else begin
         ack_q <= '0;
         case (state_q)
            IDLE: begin
               if (win_valid && !tx_busy) begin
                  grant_id_q <= winner;
                  rr_ptr_q   <= winner;
                  state_q    <= ISSUE;
`ifdef UART_SRC_TAG_EN
                  tx_data_q   <= uart_src_tag(4'(winner));
                  data_hold_q <= win_byte;
                  tag_phase_q <= 1'b1;
`else
                  tx_data_q   <= win_byte;
`endif
               end
            end
            ISSUE: begin
               if (accepted) begin
                  tx_wr_en_q <= 1'b0;
`ifdef UART_SRC_TAG_EN
                  if (tag_phase_q) begin
                     state_q <= ACCEPT;
                  end else begin
                     ack_q   <= grant_onehot;
                     state_q <= DRAIN;
                  end
`else
                  ack_q   <= grant_onehot;
                  state_q <= DRAIN;
`endif
               end else begin
                  tx_wr_en_q <= 1'b1;
               end
            end
`ifdef UART_SRC_TAG_EN
            ACCEPT: begin
               if (!tx_busy) begin
                  tx_data_q   <= data_hold_q;
                  tag_phase_q <= 1'b0;
                  state_q     <= ISSUE;
               end
            end
`endif
            DRAIN: begin
               if (!tx_busy) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack      = ack_q;
   assign tx_wr_en = tx_wr_en_q;
   assign tx_data  = tx_data_q;
   assign grant_id = grant_id_q;
   assign active   = (state_q != IDLE);

endmodule
